dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port synchronous data memory between several requesters, such as the UART memory interface, processor cores and a debug dump port. It replaces per-state address/data/write-enable muxing with registered round-robin grants, a burst limit and per-requester masking. It sits between the requesters and the data RAM, which has a 1-cycle read latency. The top-level sequencer drives `req_mask` to admit only the requesters valid in its current phase.

## Interface
- `NUM_REQ`, 3: number of requesters (≥2).
- `DATA_WIDTH`, 12: memory word width.
- `ADDR_WIDTH`, 12: memory address width.
- `MAX_BURST`, 16: accesses an unlocked owner may issue before yielding if others wait.

Ports:
- `clk`  in  1  clock.
- `rstN`  in  1  reset, synchronous, active-low.
- `req`  in  NUM_REQ  per-requester access request, held until done.
- `lock`  in  NUM_REQ  owner exempt from burst limit while high.
- `req_mask`  in  NUM_REQ  1 = requester eligible; from top-level sequencer.
- `wrEn`  in  NUM_REQ  per-requester write enable.
- `addr`  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata`  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
- `gnt`  out  NUM_REQ  registered one-hot (or zero) grant.
- `rvalid`  out  NUM_REQ  one-hot read-data-valid, 1 cycle after a granted read.
- `rdata`  out  DATA_WIDTH  shared read data (mem_dataOut passthrough).
- `mem_addr`  out  ADDR_WIDTH  to RAM address.
- `mem_wrEn`  out  1  to RAM write enable.
- `mem_dataIn`  out  DATA_WIDTH  to RAM data in.
- `mem_dataOut`  in  DATA_WIDTH  from RAM data out.

## Operation
- Effective request: `ereq = req & req_mask`.
- States:
  - IDLE: no owner.
  - OWN: one owner; `gnt` equals the owner one-hot.
- Access issue:
  - An access happens in any cycle where `gnt[i] & ereq[i]`.
  - `mem_addr`, `mem_dataIn` and `mem_wrEn` come combinationally from requester i.
  - `mem_wrEn = wrEn[i]`.
  - With no access: `mem_wrEn = 0`; `mem_addr` and `mem_dataIn` are held at owner/last values (don't-care, but never X).
- Read return: `rvalid[i]` pulses the cycle after a read access by i.
- Priority pick:
  - Round-robin starting at `last_owner+1` modulo NUM_REQ, over ereq.
  - Reset sets `last_owner = NUM_REQ-1`, so requester 0 wins first.
- IDLE → OWN: any ereq. Picked requester's `gnt` rises next cycle; `last_owner` is updated.
- OWN, burst counting: `burst_cnt` increments on each access. It saturates/resets as follows.
- OWN → release when either:
  - `ereq[owner]=0` (request dropped or masked off), or
  - `burst_cnt` reaches MAX_BURST with `lock[owner]=0` and another ereq pending.
- On release:
  - If another ereq is pending: hand over directly to the next round-robin winner next cycle. No idle cycle; `burst_cnt` cleared.
  - Else: go to IDLE, `gnt=0`.
- Burst limit reached with no other ereq pending: keep the grant, clear `burst_cnt`.
- Mask drop mid-burst:
  - The access is suppressed in that same cycle (ereq gates issue).
  - Grant is released next cycle.
  - An rvalid already in flight still pulses.
- Simultaneous requests in IDLE: round-robin decides; exactly one grant.
- `gnt` is always one-hot or zero; `rvalid` is always one-hot or zero.

## Timing
- Reset values (rstN=0 at clk edge): `gnt=0`, `rvalid=0`, state IDLE, `burst_cnt=0`, `last_owner=NUM_REQ-1`. `mem_wrEn=0` as a consequence of `gnt=0`.
- Reset mid-burst:
  - All outputs return to reset values next cycle.
  - A pending rvalid is dropped.
  - A write presented in the reset cycle is not performed, because `gnt` is already 0 after the edge.
- Grant latency: ereq high in cycle 0 (IDLE) → `gnt` cycle 1 → first access cycle 1.
- Read latency: read issued in cycle n → `rdata` with `rvalid` in cycle n+1.
- Write: committed at the rising edge ending the access cycle.
- Handover: old owner's last access in cycle n → new owner's `gnt` and access in cycle n+1.
- Throughput: one access per cycle sustained.
- Requester rule: a requester may change addr/wdata/wrEn every cycle while granted.

## Structure
- Shared package/header `dmem_arb_pkg`, holding:
  - State encodings IDLE/OWN.
  - Default MAX_BURST.
  - Flattened-bus slice helper widths.
- Sub-module `rr_priority_picker`, parameter `N`:
  - Inputs: `ereq`, `last_owner`.
  - Outputs: one-hot `pick` and `any`.
  - Purely combinational; instantiated once.
- All remaining logic (FSM, burst counter, rvalid register, memory mux) lives in `dmem_arbiter`.

## Test plan
- Single requester: reset, then requester 1 writes 0xABC to addr 7 and reads it back → `gnt[1]` rises 1 cycle after req; `rdata=0xABC`, `rvalid[1]=1` the cycle after the read.
- Simultaneous req=3'b111 from reset with MAX_BURST=4 → grants 0,1,2,0 in turn, 4 accesses each, no dead cycles; `gnt` always one-hot.
- Lock: requester 2 holds `lock=1` for 20 accesses while requester 0 waits → `gnt[2]` held all 20; `gnt[0]` the cycle after `req[2]` drops.
- Mask: `req_mask` bit of the owner is cleared mid-burst with a write pending → no `mem_wrEn` that cycle; `gnt` moves to the waiting requester or to 0 next cycle.
- Burst limit, single requester: requester 0 alone for 40 accesses, MAX_BURST=16 → grant never drops.
- Reset mid-read: `rstN=0` in the cycle after a read issue → `rvalid=0`, `gnt=0` next cycle; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default sizes
// and the index-width helper used to size owner/last_owner fields.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ    = 3;
    localparam int DEFAULT_DATA_WIDTH = 12;
    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_MAX_BURST  = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set ereq bit strictly after
// last_owner, wrapping around so last_owner itself comes last.
module rr_priority_picker
    import dmem_arb_pkg::*;
#(
    parameter int N = DEFAULT_NUM_REQ
) (
    input  logic [N-1:0]              ereq,
    input  logic [idx_width(N)-1:0]   last_owner,
    output logic [N-1:0]              pick,
    output logic                      any
);

    logic [N-1:0] upper;
    logic [N-1:0] src;
    logic         found;

    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            if (i > int'(last_owner)) upper[i] = 1'b1;
        end
        // Prefer requesters above last_owner; otherwise wrap to the bottom.
        src = (|(ereq & upper)) ? (ereq & upper) : ereq;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (src[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        any = |ereq;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between
// requesters, with a burst limit, per-owner lock and sequencer masking.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            req_mask,
    input  logic [NUM_REQ-1:0]            wrEn,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_wrEn,
    output logic [DATA_WIDTH-1:0]         mem_dataIn,
    input  logic [DATA_WIDTH-1:0]         mem_dataOut
);

    localparam int OW = idx_width(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 2);

    arb_state_t            state;
    logic [OW-1:0]         owner;
    logic [OW-1:0]         last_owner;
    logic [OW-1:0]         pick_idx;
    logic [BW-1:0]         burst_cnt;
    logic [BW-1:0]         burst_inc;
    logic [NUM_REQ-1:0]    ereq;
    logic [NUM_REQ-1:0]    pick;
    logic                  any;
    logic                  access;
    logic                  others;
    logic                  limit_hit;
    logic                  wr_sel;
    logic                  lock_sel;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    assign ereq      = req & req_mask;
    assign access    = |(gnt & ereq);
    assign others    = |(ereq & ~gnt);
    assign burst_inc = burst_cnt + BW'(1);
    assign limit_hit = burst_inc >= BW'(MAX_BURST);

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .ereq       (ereq),
        .last_owner (last_owner),
        .pick       (pick),
        .any        (any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = OW'(i);
        end
    end

    // Owner index drives the RAM mux even while idle, so the bus never floats.
    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        wr_sel    = 1'b0;
        lock_sel  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == OW'(i)) begin
                addr_sel  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_sel = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                wr_sel    = wrEn[i];
                lock_sel  = lock[i];
            end
        end
    end

    assign mem_addr   = addr_sel;
    assign mem_dataIn = wdata_sel;
    assign mem_wrEn   = access & wr_sel;
    assign rdata      = mem_dataOut;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= OW'(NUM_REQ - 1);
            last_owner <= OW'(NUM_REQ - 1);
            burst_cnt  <= '0;
            rvalid     <= '0;
        end else begin
            rvalid <= gnt & ereq & {NUM_REQ{~wr_sel}};
            case (state)
                IDLE: begin
                    if (any) begin
                        state      <= OWN;
                        gnt        <= pick;
                        owner      <= pick_idx;
                        last_owner <= pick_idx;
                        burst_cnt  <= '0;
                    end
                end
                OWN: begin
                    if (!access || (limit_hit && !lock_sel && others)) begin
                        burst_cnt <= '0;
                        if (any) begin
                            gnt        <= pick;
                            owner      <= pick_idx;
                            last_owner <= pick_idx;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else if (limit_hit) begin
                        // Locked owner with waiters saturates so it yields as soon as lock drops.
                        burst_cnt <= others ? BW'(MAX_BURST) : '0;
                    end else begin
                        burst_cnt <= burst_inc;
                    end
                end
            endcase
        end
    end

endmodule
